// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default parameters for the pipeline sequencer
package pipe_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/pipe_seq_if.sv
// pipe_seq_if: hazard/memory event inputs and stage control outputs of the sequencer
interface pipe_seq_if import pipe_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
);
  logic hazard_nop, mispredict, dmem_req, dmem_ack;
  logic stall_if, stall_id, stall_ex, stall_mem;
  logic flush_id, flush_ex, redirect, dmem_abort, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output hazard_nop, mispredict, dmem_req, dmem_ack,
    input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
    input  redirect, dmem_abort, mem_err, stall_cnt, flush_cnt
  );
  modport slave (
    input  hazard_nop, mispredict, dmem_req, dmem_ack,
    output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
    output redirect, dmem_abort, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_cnt.sv
// sat_cnt: enabled up-counter that holds at all-ones
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_en && r_cnt != '1) r_cnt <= r_cnt + W'(1);
  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_seq.sv
// pipe_seq: pipeline stall/flush sequencer for load-use hazards, mispredicts and memory waits
// Control outputs are Mealy on state and inputs; mem_err and the perf counters are registered.
module pipe_seq import pipe_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic       clk,
  input logic       rst_n,
  pipe_seq_if.slave bus
);
  state_t r_state, w_next;
  logic [7:0] r_wait;
  logic r_mem_err;
  logic w_mem_hold, w_abort, w_ev, w_mis, w_haz;
  logic w_stall_fe, w_stall_be, w_flush_id, w_flush_ex;
  logic [CNT_W-1:0] w_stall_cnt, w_flush_cnt;
  // w_ev marks cycles where mispredict/hazard_nop are honoured: RUN without a new wait, or the ack cycle
  assign w_mem_hold = rst_n && !bus.dmem_ack &&
                      ((r_state == RUN && bus.dmem_req) || (r_state == MEM_WAIT && r_wait != 8'(TIMEOUT)));
  assign w_abort    = rst_n && r_state == MEM_WAIT && !bus.dmem_ack && r_wait == 8'(TIMEOUT);
  assign w_ev       = rst_n && ((r_state == RUN && !w_mem_hold) || (r_state == MEM_WAIT && bus.dmem_ack));
  assign w_mis      = w_ev && bus.mispredict;
  assign w_haz      = w_ev && !bus.mispredict && bus.hazard_nop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= RUN;
      r_wait    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_wait    <= w_mem_hold ? (r_state == MEM_WAIT ? r_wait + 8'd1 : 8'd1) : r_wait;
      r_mem_err <= r_mem_err | w_abort;
    end
  always_comb w_next = w_mem_hold ? MEM_WAIT : w_mis ? FLUSH : RUN;
  always_comb begin
    w_stall_fe = w_mem_hold || w_haz;
    w_stall_be = w_mem_hold;
    w_flush_id = w_mis || (rst_n && r_state == FLUSH);
    w_flush_ex = w_mis || w_haz;
  end
  assign bus.stall_if   = w_stall_fe;
  assign bus.stall_id   = w_stall_fe;
  assign bus.stall_ex   = w_stall_be;
  assign bus.stall_mem  = w_stall_be;
  assign bus.flush_id   = w_flush_id;
  assign bus.flush_ex   = w_flush_ex;
  assign bus.redirect   = w_mis;
  assign bus.dmem_abort = w_abort;
  assign bus.mem_err    = r_mem_err;
  assign bus.stall_cnt  = w_stall_cnt;
  assign bus.flush_cnt  = w_flush_cnt;
  sat_cnt #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .i_en(w_stall_fe), .o_cnt(w_stall_cnt));
  sat_cnt #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .i_en(w_mis), .o_cnt(w_flush_cnt));
endmodule

// File: tb/tb_pipe_seq.sv
// tb_pipe_seq: directed and randomized checks of pipe_seq against an in-bench reference model
module tb_pipe_seq;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int waited = 0;
  int scnt = 0;
  int fcnt = 0;
  bit flushing = 1'b0;
  bit err = 1'b0;
  pipe_seq_if #(.CNT_W(CW)) bus();
  pipe_seq #(.TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // control vector order: stall_if stall_id stall_ex stall_mem flush_id flush_ex redirect dmem_abort
  function automatic logic [7:0] outs();
    return {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem,
            bus.flush_id, bus.flush_ex, bus.redirect, bus.dmem_abort};
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask
  // reference model: an outstanding access counts its waiting cycles; a mispredict leaves one flush cycle pending
  always @(negedge clk) begin
    logic [7:0] e;
    int nw;
    bit nf, ab;
    e = '0; nw = 0; nf = 0; ab = 0;
    if (!rst_n) begin
      waited = 0; flushing = 0; err = 0; scnt = 0; fcnt = 0;
    end else if (flushing) e[3] = 1'b1;
    else if (waited == TO && !bus.dmem_ack) begin
      e[0] = 1'b1; ab = 1'b1;
    end else if (!bus.dmem_ack && (waited > 0 || bus.dmem_req)) begin
      e[7:4] = 4'hF; nw = waited + 1;
    end else if (bus.mispredict) begin
      e[3:1] = 3'b111; nf = 1'b1;
    end else if (bus.hazard_nop) e = 8'b1100_0100;
    check("ctrl", 32'(outs()), 32'(e));
    check("mem_err", 32'(bus.mem_err), 32'(err));
    check("stall_cnt", 32'(bus.stall_cnt), scnt);
    check("flush_cnt", 32'(bus.flush_cnt), fcnt);
    if (rst_n) begin
      waited = nw; flushing = nf; err = err | ab;
      if (e[7] && scnt < MAXC) scnt++;
      if (e[1] && fcnt < MAXC) fcnt++;
    end
  end
  task automatic cyc(input bit h, input bit m, input bit rq, input bit ak);
    @(posedge clk); #1;
    bus.hazard_nop = h; bus.mispredict = m; bus.dmem_req = rq; bus.dmem_ack = ak;
    @(negedge clk);
  endtask
  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.hazard_nop = 1; bus.mispredict = 1; bus.dmem_req = 1; bus.dmem_ack = 0;
    @(negedge clk);
    check("rst_ctrl", 32'(outs()), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.hazard_nop = 0; bus.mispredict = 0; bus.dmem_req = 0; bus.dmem_ack = 0;
  endtask
  initial begin
    bus.hazard_nop = 0; bus.mispredict = 0; bus.dmem_req = 0; bus.dmem_ack = 0;
    repeat (2) cyc(1, 1, 1, 0);
    check("rst_hold", 32'(outs()), 0);
    check("rst_cnt", 32'({bus.stall_cnt, bus.flush_cnt, bus.mem_err}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.hazard_nop = 0; bus.mispredict = 0; bus.dmem_req = 0;
    cyc(0, 0, 0, 0);
    check("idle", 32'(outs()), 0);
    cyc(1, 0, 0, 0);
    check("haz_ctrl", 32'(outs()), 'hC4);
    cyc(0, 0, 0, 0);
    check("haz_cnt", 32'(bus.stall_cnt), 1);
    cyc(0, 1, 0, 0);
    check("mis_ctrl", 32'(outs()), 'h0E);
    cyc(1, 1, 0, 0);
    check("flush_ctrl", 32'(outs()), 'h08);
    check("mis_fcnt", 32'(bus.flush_cnt), 1);
    cyc(0, 0, 0, 0);
    check("after_flush", 32'(outs()), 0);
    pulse_reset();
    repeat (3) begin
      cyc(0, 0, 1, 0);
      check("mw_stall", 32'(outs()), 'hF0);
    end
    cyc(0, 0, 1, 1);
    check("ack_ctrl", 32'(outs()), 0);
    cyc(0, 0, 0, 0);
    check("mw_cnt", 32'(bus.stall_cnt), 3);
    pulse_reset();
    repeat (3) begin
      cyc(0, 1, 1, 0);
      check("mw_mis_stall", 32'(outs()), 'hF0);
    end
    cyc(0, 1, 1, 1);
    check("ack_mis", 32'(outs()), 'h0E);
    cyc(0, 0, 0, 0);
    check("ack_flush", 32'(outs()), 'h08);
    check("ack_fcnt", 32'(bus.flush_cnt), 1);
    pulse_reset();
    repeat (4) begin
      cyc(0, 0, 1, 0);
      check("to_stall", 32'(outs()), 'hF0);
    end
    cyc(0, 0, 1, 0);
    check("to_abort", 32'(outs()), 'h01);
    check("to_err_pre", 32'(bus.mem_err), 0);
    repeat (5) cyc(0, 0, 0, 0);
    check("to_idle", 32'(outs()), 0);
    check("to_err", 32'(bus.mem_err), 1);
    pulse_reset();
    cyc(0, 0, 0, 0);
    check("err_clear", 32'(bus.mem_err), 0);
    repeat (20) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("sat_stall", 32'(bus.stall_cnt), 15);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.hazard_nop = 1; bus.mispredict = 1;
    @(negedge clk);
    check("mid_rst_ctrl", 32'(outs()), 0);
    check("mid_rst_cnt", 32'(bus.stall_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mispredict = 0; bus.dmem_req = 0;
    @(negedge clk);
    check("rel_run", 32'(outs()), 'hC4);
    for (int p = 0; p < 3; p++) begin
      repeat (1000) begin
        @(posedge clk); #1;
        rst_n = ($urandom_range(0, 199) != 0);
        bus.hazard_nop = ($urandom_range(0, 3) == 0);
        bus.mispredict = ($urandom_range(0, 4) == 0);
        bus.dmem_req   = ($urandom_range(0, 2) == 0);
        bus.dmem_ack   = ($urandom_range(0, 99) < (p == 1 ? 10 : 50));
        @(negedge clk);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
